multiword_addsub_seq: RTL and testbench
=======================================

Name: multiword_addsub_seq

Overview:
Sequential controller that performs wide (n*m-bit) two's-complement add/subtract by reusing one n-bit ripple add/sub slice over m cycles, least-significant chunk first, with carry chained through a register. Sits between a requester (start/done handshake) and the narrow adder datapath. Trades latency for area in wide arithmetic.

Parameters:
n, 8, chunk width = width of the shared add/sub slice
m, 4, number of chunks; operand width W = n*m (m >= 2)

Ports:
Clock  input  1  single system clock, rising edge
Reset  input  1  synchronous, active-high reset
Start  input  1  request; sampled only in IDLE
SUB  input  1  0 = A+B, 1 = A-B; latched with Start
A  input  W  operand A; latched with Start
B  input  W  operand B; latched with Start
Result  output  W  sum/difference; valid from Done, held until next accepted Start
Cout  output  1  final carry out of bit W-1 (SUB: 1 = no borrow)
V  output  1  signed overflow of the W-bit operation
Busy  output  1  high while operation in progress
Done  output  1  one-cycle pulse, result valid

Behaviour:
- Clock is Clock; Reset is synchronous, active-high; one clock domain.
- Reset: state IDLE; Result=0, Cout=0, V=0, Busy=0, Done=0, chunk counter=0, carry reg=0.
- States: IDLE, RUN, DONE.
- IDLE: Start=1 -> latch A, B, SUB into operand shift registers; carry reg <= SUB; counter <= 0; go RUN; Busy=1 next cycle. Start=0 -> stay.
- RUN: each cycle slice computes chunk k: Sk = Ak + (Bk XOR {n{SUB}}) + carry reg. Sk shifted into Result from MSB side (after m cycles lands LSB-aligned); carry reg <= slice carry; operands shift right by n; counter++.
- Carry uses the effectively inverted B chunk (correct two's-complement; carry and sum both see B XOR SUB).
- When counter = m-1 (last chunk): Cout <= slice carry; V <= overflow from MSBs of last chunk: (A_msb == Beff_msb) && (S_msb != A_msb); go DONE.
- DONE: Done=1 for exactly this cycle, Busy=0; go IDLE. Result/Cout/V hold.
- Latency: Start sampled at edge t -> Done high in cycle t+m+1 (5 cycles for m=4). Back-to-back: new Start accepted in cycle after DONE.
- Start during RUN/DONE ignored; latched operands unaffected by A/B/SUB changes after acceptance.
- Result, Cout, V not cleared on new Start; updated only as chunks complete (Result reflects partial shifting during RUN; only meaningful when Done/IDLE).
- Reset mid-operation: abort, all outputs/state to reset values next edge; no Done pulse.
- Wrap-around: Result is modulo 2^W; no saturation.

Optional Feature:
Macro ADDSUB_ACCUM_EN. Defined: extra input port Acc (1 bit); when Start=1 and Acc=1 in IDLE, operand A is taken from current Result instead of port A (running accumulate/decumulate); Acc ignored outside IDLE. Not defined: Acc port absent, A always from port.

Decomposition:
- Shared package/header addsub_pkg: state encodings (IDLE, RUN, DONE), counter width constant clog2(m), default n/m.
- One sub-module: addsub_chunk (combinational n-bit slice: inputs x, y, sub, cin; outputs s, cout, ovf), instantiated once; controller owns all registers.

Test Plan:
- n=8,m=4: A=0x000000FF, B=0x00000001, SUB=0, Start -> Done 5 cycles later, Result=0x00000100, Cout=0, V=0; Done pulses one cycle.
- SUB=1, A=0x00000000, B=0x00000001 -> Result=0xFFFFFFFF, Cout=0, V=0.
- SUB=0, A=0x7FFFFFFF, B=0x00000001 -> Result=0x80000000, Cout=0, V=1; SUB=0, A=0xFFFFFFFF, B=1 -> Result=0, Cout=1, V=0.
- SUB=1, A=0x80000000, B=0x00000001 -> Result=0x7FFFFFFF, Cout=1, V=1.
- Start op A=5,B=3 ADD; pulse Start with A=0xFFFF,B=0xFFFF two cycles later, change A/B -> second Start ignored, Result=0x00000008; Reset asserted in RUN cycle 2 of next op -> Busy=0, Result=0, no Done.
- ADDSUB_ACCUM_EN: Result=0x10, Start Acc=1, B=0x05, SUB=1 -> Result=0x0B, Cout=1, V=0.

Source files
------------

// File: rtl/addsub_pkg.sv
// Shared definitions for the multi-word add/subtract sequencer: FSM state
// encoding and default slice geometry.
package addsub_pkg;

  localparam int N_DEF     = 8;
  localparam int M_DEF     = 4;
  localparam int CNT_W_DEF = $clog2(M_DEF);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/addsub_chunk.sv
// Combinational n-bit two's-complement add/subtract slice with carry in/out
// and signed-overflow flag for the most significant chunk.
module addsub_chunk #(
  parameter int n = 8
) (
  input  logic [n-1:0] x,
  input  logic [n-1:0] y,
  input  logic         sub,
  input  logic         cin,
  output logic [n-1:0] s,
  output logic         cout,
  output logic         ovf
);

  logic [n-1:0] y_eff;
  logic [n:0]   sum;

  // Sum and carry both see the inverted B chunk so subtraction is exact.
  assign y_eff = y ^ {n{sub}};
  assign sum   = {1'b0, x} + {1'b0, y_eff} + (n+1)'(cin);
  assign s     = sum[n-1:0];
  assign cout  = sum[n];
  assign ovf   = (x[n-1] == y_eff[n-1]) && (s[n-1] != x[n-1]);

endmodule

// File: rtl/multiword_addsub_seq.sv
// Wide (n*m-bit) add/subtract done over m cycles with one shared n-bit slice,
// least-significant chunk first. `ADDSUB_ACCUM_EN adds an Acc input that takes
// operand A from the current Result.
module multiword_addsub_seq
  import addsub_pkg::*;
#(
  parameter int n = N_DEF,
  parameter int m = M_DEF
) (
  input  logic           Clock,
  input  logic           Reset,
  input  logic           Start,
  input  logic           SUB,
`ifdef ADDSUB_ACCUM_EN
  input  logic           Acc,
`endif
  input  logic [n*m-1:0] A,
  input  logic [n*m-1:0] B,
  output logic [n*m-1:0] Result,
  output logic           Cout,
  output logic           V,
  output logic           Busy,
  output logic           Done
);

  localparam int W     = n * m;
  localparam int CNT_W = $clog2(m);

  state_t           state_q, state_d;
  logic [W-1:0]     a_q, a_d;
  logic [W-1:0]     b_q, b_d;
  logic             sub_q, sub_d;
  logic             carry_q, carry_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [W-1:0]     result_q, result_d;
  logic             cout_q, cout_d;
  logic             v_q, v_d;

  logic [W-1:0]     a_src;
  logic [n-1:0]     slice_s;
  logic             slice_cout;
  logic             slice_ovf;

`ifdef ADDSUB_ACCUM_EN
  assign a_src = Acc ? result_q : A;
`else
  assign a_src = A;
`endif

  addsub_chunk #(.n(n)) u_chunk (
    .x    (a_q[n-1:0]),
    .y    (b_q[n-1:0]),
    .sub  (sub_q),
    .cin  (carry_q),
    .s    (slice_s),
    .cout (slice_cout),
    .ovf  (slice_ovf)
  );

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    sub_d    = sub_q;
    carry_d  = carry_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    cout_d   = cout_q;
    v_d      = v_q;
    unique case (state_q)
      ST_IDLE: begin
        if (Start) begin
          a_d     = a_src;
          b_d     = B;
          sub_d   = SUB;
          carry_d = SUB;
          cnt_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        // Each chunk enters at the top so after m shifts the result is LSB-aligned.
        result_d = {slice_s, result_q[W-1:n]};
        carry_d  = slice_cout;
        a_d      = a_q >> n;
        b_d      = b_q >> n;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(m - 1)) begin
          cout_d  = slice_cout;
          v_d     = slice_ovf;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q  <= ST_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      sub_q    <= 1'b0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      result_q <= '0;
      cout_q   <= 1'b0;
      v_q      <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      sub_q    <= sub_d;
      carry_q  <= carry_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      v_q      <= v_d;
    end
  end

  assign Result = result_q;
  assign Cout   = cout_q;
  assign V      = v_q;
  assign Busy   = (state_q == ST_RUN);
  assign Done   = (state_q == ST_DONE);

endmodule

// File: tb/tb_multiword_addsub_seq.sv
// Scoreboard bench for multiword_addsub_seq (n=8, m=4): directed vectors push
// expected results, a monitor checks them on every Done pulse.
module tb_multiword_addsub_seq;

  localparam int N = 8;
  localparam int M = 4;
  localparam int W = N * M;

  typedef struct packed {
    logic [W-1:0] res;
    logic         c;
    logic         v;
  } exp_t;

  logic         Clock = 1'b0;
  logic         Reset;
  logic         Start;
  logic         SUB;
`ifdef ADDSUB_ACCUM_EN
  logic         Acc;
`endif
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic [W-1:0] Result;
  logic         Cout;
  logic         V;
  logic         Busy;
  logic         Done;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  always #5 Clock = ~Clock;

  multiword_addsub_seq #(.n(N), .m(M)) dut (
    .Clock  (Clock),
    .Reset  (Reset),
    .Start  (Start),
    .SUB    (SUB),
`ifdef ADDSUB_ACCUM_EN
    .Acc    (Acc),
`endif
    .A      (A),
    .B      (B),
    .Result (Result),
    .Cout   (Cout),
    .V      (V),
    .Busy   (Busy),
    .Done   (Done)
  );

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
    end
  endtask

  // Monitor: every Done pulse must match the oldest outstanding expectation.
  always @(negedge Clock) begin
    if (Done === 1'b1) begin
      exp_t e;
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_done: got Result 0x%08h, expected no Done pulse", Result);
      end else begin
        e = sb.pop_front();
        check("result", Result, e.res);
        check("cout", W'(Cout), W'(e.c));
        check("ovf", W'(V), W'(e.v));
      end
    end
  end

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                        input logic acc, input logic [W-1:0] er, input logic ec,
                        input logic ev);
    int lat;
    exp_t e;
    e.res = er; e.c = ec; e.v = ev;
`ifdef ADDSUB_ACCUM_EN
    Acc = acc;
`else
    if (acc) $display("note: accumulate requested without ADDSUB_ACCUM_EN");
`endif
    A = a; B = b; SUB = sub; Start = 1'b1;
    sb.push_back(e);
    @(negedge Clock);
    Start = 1'b0;
    A = ~a; B = ~b; SUB = ~sub;
`ifdef ADDSUB_ACCUM_EN
    Acc = 1'b0;
`endif
    check("busy_after_start", W'(Busy), W'(1));
    lat = 1;
    while (Done !== 1'b1 && lat < 20) begin
      @(negedge Clock);
      lat++;
    end
    check("latency", W'(lat), W'(5));
    @(negedge Clock);
    check("done_one_cycle", W'({Done, Busy}), W'(0));
  endtask

  initial begin
    Reset = 1'b1; Start = 1'b0; SUB = 1'b0; A = '0; B = '0;
`ifdef ADDSUB_ACCUM_EN
    Acc = 1'b0;
`endif
    repeat (2) @(negedge Clock);
    Reset = 1'b0;
    check("reset_result", Result, 32'h0);
    check("reset_flags", W'({Cout, V, Busy, Done}), W'(0));
    @(negedge Clock);

    run_op(32'h000000FF, 32'h00000001, 1'b0, 1'b0, 32'h00000100, 1'b0, 1'b0);
    run_op(32'h00000000, 32'h00000001, 1'b1, 1'b0, 32'hFFFFFFFF, 1'b0, 1'b0);
    run_op(32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1);
    run_op(32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0);
    run_op(32'h80000000, 32'h00000001, 1'b1, 1'b0, 32'h7FFFFFFF, 1'b1, 1'b1);
    run_op(32'h12345678, 32'h11111111, 1'b0, 1'b0, 32'h23456789, 1'b0, 1'b0);
    run_op(32'h00000005, 32'h00000005, 1'b1, 1'b0, 32'h00000000, 1'b1, 1'b0);

    // Start during RUN is ignored and input changes do not disturb latched operands.
    begin
      exp_t e;
      int lat;
      e.res = 32'h00000008; e.c = 1'b0; e.v = 1'b0;
      A = 32'h5; B = 32'h3; SUB = 1'b0; Start = 1'b1;
      sb.push_back(e);
      @(negedge Clock);
      Start = 1'b0;
      @(negedge Clock);
      A = 32'hFFFF; B = 32'hFFFF; Start = 1'b1;
      @(negedge Clock);
      Start = 1'b0; A = 32'hDEADBEEF; B = 32'h12345678; SUB = 1'b1;
      lat = 3;
      while (Done !== 1'b1 && lat < 20) begin
        @(negedge Clock);
        lat++;
      end
      check("latency_ignored_start", W'(lat), W'(5));
      repeat (8) @(negedge Clock);
      check("no_second_op", W'(sb.size()), W'(0));
    end

    // Reset in the middle of an operation aborts it without a Done pulse.
    A = 32'h01010101; B = 32'h02020202; SUB = 1'b0; Start = 1'b1;
    @(negedge Clock);
    Start = 1'b0;
    @(negedge Clock);
    Reset = 1'b1;
    @(negedge Clock);
    Reset = 1'b0;
    check("abort_busy", W'(Busy), W'(0));
    check("abort_result", Result, 32'h0);
    check("abort_flags", W'({Cout, V, Done}), W'(0));
    repeat (8) @(negedge Clock);

`ifdef ADDSUB_ACCUM_EN
    run_op(32'h00000010, 32'h00000000, 1'b0, 1'b0, 32'h00000010, 1'b0, 1'b0);
    run_op(32'hCAFEF00D, 32'h00000005, 1'b1, 1'b1, 32'h0000000B, 1'b1, 1'b0);
`endif

    repeat (4) @(negedge Clock);
    check("scoreboard_drained", W'(sb.size()), W'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: got no end of test, expected completion");
    $fatal(1);
  end

endmodule
